// File: rtl/tb_out_reorder.sv
// Ping-pong reorder buffer behind the traceback unit: collects TBL newest-first
// decoded bits per block and re-emits them oldest-first on a valid/ready stream.
module tb_out_reorder #(
  parameter int TBL    = 15,
  parameter int ADDR_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_i,
  input  logic bit_valid_i,
  output logic data_o,
  output logic valid_o,
  input  logic ready_i,
  output logic last_o,
  output logic overflow_o
);

  localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(TBL - 1);

  logic [TBL-1:0]    mem [2];
  logic              wr_bank, rd_bank;
  logic [ADDR_W-1:0] wr_cnt, rd_cnt, wr_idx;
  logic [1:0]        full, full_nxt;
  logic              overflow_q;
  logic              accept, wr_done, xfer, rd_done;

  // A write only targets an empty bank and a read only a full one, so the
  // set and clear below never hit the same bank in one cycle.
  always_comb begin
    accept   = bit_valid_i & ~full[wr_bank];
    wr_done  = accept & (wr_cnt == CNT_MAX);
    wr_idx   = CNT_MAX - wr_cnt;
    valid_o  = full[rd_bank];
    last_o   = valid_o & (rd_cnt == CNT_MAX);
    data_o   = valid_o & mem[rd_bank][rd_cnt];
    xfer     = valid_o & ready_i;
    rd_done  = xfer & last_o;
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
  end

  assign overflow_o = overflow_q;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank][wr_idx] <= bit_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      full       <= '0;
      overflow_q <= 1'b0;
    end else begin
      full <= full_nxt;
      if (bit_valid_i & full[wr_bank]) overflow_q <= 1'b1;
      if (wr_done) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else if (accept) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (rd_done) begin
        rd_cnt  <= '0;
        rd_bank <= ~rd_bank;
      end else if (xfer) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

endmodule
